rgb_conv_sequencer: RTL and testbench

Frame-level controller for the 3-channel 3x3 systolic convolution datapath. On a start pulse it loads the three kernels, then streams the image one 3-row band at a time: it requests columns from the pixel source through a valid/ready handshake, drives the array's col and start_conv controls, and counts combined RGB results. It tags each result with output row/column coordinates and flags frame completion or protocol errors. It sits between the frame buffer/DMA and the RGB array.

---
 rtl/rgb_conv_sequencer.sv | 152 +++++++++++++++
 tb/tb_rgb_conv_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rgb_conv_sequencer.sv
// Frame controller for the 3-channel 3x3 systolic convolution array: loads kernels, streams
// 3-row bands column by column, tags combined RGB results and flags completion/protocol errors.
module rgb_conv_sequencer #(
  parameter int unsigned IMG_W        = 224,
  parameter int unsigned IMG_H        = 224,
  parameter int unsigned WLOAD_CYCLES = 1,
  parameter int unsigned DRAIN_MAX    = 16,
  parameter int unsigned CW           = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          load_weight,
  output logic          start_conv,
  output logic          col,
  input  logic          src_valid,
  output logic          src_ready,
  output logic [CW-1:0] src_row,
  output logic [CW-1:0] src_col,
  input  logic          conv_valid,
  output logic [CW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          out_last,
  output logic          error
);

  localparam int unsigned TMax = (DRAIN_MAX > WLOAD_CYCLES) ? DRAIN_MAX : WLOAD_CYCLES;
  localparam int unsigned TW   = $clog2(TMax + 1);
  localparam int unsigned CW1  = CW + 1;

  localparam logic [CW:0]   ColEnd   = CW1'(IMG_W);
  localparam logic [CW-1:0] ColLast  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] OutFull  = CW'(IMG_W - 2);
  localparam logic [CW-1:0] OutLast  = CW'(IMG_W - 3);
  localparam logic [CW-1:0] BandLast = CW'(IMG_H - 3);
  localparam logic [TW-1:0] WloadEnd = TW'(WLOAD_CYCLES - 1);
  localparam logic [TW-1:0] DrainEnd = TW'(DRAIN_MAX - 1);

  typedef enum logic [2:0] {StIdle, StLoadW, StStream, StDrain, StGap, StFinish} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] band_q, band_d;
  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          error_q, error_d;
  logic          err_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      band_q    <= '0;
      col_cnt_q <= '0;
      out_cnt_q <= '0;
      tmr_q     <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      band_q    <= band_d;
      col_cnt_q <= col_cnt_d;
      out_cnt_q <= out_cnt_d;
      tmr_q     <= tmr_d;
      error_q   <= error_d;
    end
  end

  assign busy        = (state_q == StLoadW) || (state_q == StStream) ||
                       (state_q == StDrain) || (state_q == StGap);
  assign done        = (state_q == StFinish);
  assign load_weight = (state_q == StLoadW);
  assign start_conv  = (state_q == StStream) || (state_q == StDrain);
  assign src_ready   = (state_q == StStream) && ({1'b0, col_cnt_q} < ColEnd);
  assign col         = src_valid && src_ready;
  assign src_row     = band_q;
  assign src_col     = col_cnt_q;
  assign error       = error_q;

  // Result tag is combinational so it lines up with the array's conv_valid cycle.
  assign out_row  = conv_valid ? band_q : '0;
  assign out_col  = conv_valid ? out_cnt_q : '0;
  assign out_last = conv_valid && (band_q == BandLast) && (out_cnt_q == OutLast);

  always_comb begin
    state_d   = state_q;
    band_d    = band_q;
    col_cnt_d = col_cnt_q;
    out_cnt_d = out_cnt_q;
    tmr_d     = tmr_q + 1'b1;
    error_d   = error_q;
    err_set   = 1'b0;

    unique case (state_q)
      StIdle: begin
        tmr_d = '0;
        if (start) begin
          state_d   = StLoadW;
          band_d    = '0;
          col_cnt_d = '0;
          out_cnt_d = '0;
          error_d   = 1'b0;
        end
      end
      StLoadW: begin
        if (tmr_q == WloadEnd) begin
          state_d = StStream;
          tmr_d   = '0;
        end
      end
      StStream: begin
        tmr_d = '0;
        if (col) begin
          col_cnt_d = col_cnt_q + 1'b1;
          if (col_cnt_q == ColLast) state_d = StDrain;
        end
      end
      StDrain: begin
        // A timed-out band is abandoned as if complete, with the error flagged.
        if ((out_cnt_q == OutFull) || (tmr_q == DrainEnd)) begin
          if (out_cnt_q != OutFull) err_set = 1'b1;
          state_d = (band_q == BandLast) ? StFinish : StGap;
          tmr_d   = '0;
        end
      end
      StGap: begin
        state_d   = StStream;
        band_d    = band_q + 1'b1;
        col_cnt_d = '0;
        out_cnt_d = '0;
        tmr_d     = '0;
      end
      StFinish: begin
        state_d = StIdle;
        tmr_d   = '0;
      end
      default: state_d = StIdle;
    endcase

    if (conv_valid) begin
      if ((state_q == StIdle) || (state_q == StLoadW) || (state_q == StGap)) err_set = 1'b1;
      if (out_cnt_q == OutFull) begin
        err_set = 1'b1;
      end else if ((state_q == StStream) || (state_q == StDrain)) begin
        out_cnt_d = out_cnt_q + 1'b1;
      end
    end

    if (err_set) error_d = 1'b1;
  end

endmodule

// File: tb/tb_rgb_conv_sequencer.sv
// Bench for rgb_conv_sequencer on an 8x5 image: randomized source/array behaviour checked
// against a per-frame expectation of column order, result tags, band timing and error state.
module tb_rgb_conv_sequencer;

  localparam int W  = 8;
  localparam int H  = 5;
  localparam int DM = 16;
  localparam int CW = 8;

  logic          clk, rst, start, busy, done, load_weight, start_conv, col;
  logic          src_valid, src_ready, conv_valid, out_last, error;
  logic [CW-1:0] src_row, src_col, out_row, out_col;

  int checks = 0;
  int errors = 0;

  rgb_conv_sequencer #(
    .IMG_W(W), .IMG_H(H), .WLOAD_CYCLES(1), .DRAIN_MAX(DM), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .load_weight(load_weight), .start_conv(start_conv), .col(col),
    .src_valid(src_valid), .src_ready(src_ready), .src_row(src_row), .src_col(src_col),
    .conv_valid(conv_valid), .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .error(error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {24'd0, busy, done, load_weight, start_conv, col, src_ready, out_last, error,
            src_row, src_col, out_row, out_col};
  endfunction

  function automatic int plan(input int band, input int excess_band, input int short_band);
    if (band == excess_band) return W - 1;
    if (band == short_band) return W - 3;
    return W - 2;
  endfunction

  // One frame. vmode: 0 valid tied high, 1 toggling, 2 random.
  task automatic run_frame(input int vmode, input int excess_band, input int short_band,
                           input bit poke, input int abort_band, input bit err_before);
    int band, acc, emitted, planned, drain;
    bit exp_err, tog, after_gap, poked;
    @(negedge clk);
    start = 1'b1;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_err", error, err_before);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("lw_busy", busy, 1);
    chk("lw_strobe", load_weight, 1);
    chk("lw_conv", start_conv, 0);
    chk("lw_err_clr", error, 0);
    band = 0; acc = 0; emitted = 0; drain = 0;
    exp_err = 1'b0; tog = 1'b1; after_gap = 1'b0; poked = 1'b0;
    planned = plan(band, excess_band, short_band);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      case (vmode)
        0: src_valid = 1'b1;
        1: begin src_valid = tog; tog = ~tog; end
        default: src_valid = 1'($urandom_range(0, 1));
      endcase
      conv_valid = 1'b0;
      if (acc >= 1 && emitted < planned) begin
        if (acc == W || planned != W - 2) conv_valid = 1'b1;
        else conv_valid = ($urandom_range(0, 3) != 0);
      end
      if (poke && !poked && band == 1 && acc == 3) begin
        start = 1'b1;
        poked = 1'b1;
      end
      #1;
      chk("no_reload", load_weight, 0);
      if (after_gap) begin
        chk("gap_one_cycle", start_conv, 1);
        after_gap = 1'b0;
      end
      if (acc == W && start_conv) drain++;
      if (conv_valid) begin
        chk("tag_row", out_row, band);
        chk("tag_col", out_col, (emitted < W - 2) ? emitted : W - 2);
        chk("tag_last", out_last, (band == H - 3 && emitted == W - 3));
        if (emitted >= W - 2) exp_err = 1'b1;
        emitted++;
      end else begin
        chk("last_quiet", out_last, 0);
      end
      if (col) begin
        chk("col_valid", src_valid, 1);
        chk("src_col", src_col, acc);
        chk("src_row", src_row, band);
        acc++;
      end else if (start_conv && src_valid && acc < W) begin
        chk("col_stall", col, 1);
      end
      if (band == abort_band && drain == 2) begin
        rst = 1'b0;
        #1;
        chk("rst_async_outs", all_outs(), 0);
        conv_valid = 1'b0;
        src_valid  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_idle_outs", all_outs(), 0);
        return;
      end
      if (!start_conv && acc == W) begin
        if (band == short_band) begin
          chk("drain_len", drain, DM);
          exp_err = 1'b1;
        end
        chk("band_err", error, exp_err);
        if (band == H - 3) begin
          chk("done_pulse", done, 1);
          chk("busy_fall", busy, 0);
          conv_valid = 1'b0;
          @(negedge clk);
          #1;
          chk("done_once", done, 0);
          chk("idle_after", busy, 0);
          chk("idle_err_hold", error, exp_err);
          return;
        end
        chk("gap_no_done", done, 0);
        chk("gap_busy", busy, 1);
        band++; acc = 0; emitted = 0; drain = 0; after_gap = 1'b1;
        planned = plan(band, excess_band, short_band);
      end else begin
        chk("run_busy", busy, 1);
      end
    end
    checks++;
    errors++;
    $error("FAIL frame_budget observed=timeout expected=done within 2000 cycles");
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; src_valid = 1'b0; conv_valid = 1'b0;
    #1;
    chk("reset_outs", all_outs(), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_reset_outs", all_outs(), 0);

    run_frame(0, -1, -1, 1'b0, -1, 1'b0);  // baseline, source always ready
    run_frame(1, -1, -1, 1'b1, -1, 1'b0);  // toggling source, stray start mid-stream
    run_frame(0, 0, -1, 1'b0, -1, 1'b0);   // excess result in band 0
    run_frame(2, -1, 1, 1'b0, -1, 1'b1);   // short band 1 times out in drain
    run_frame(0, -1, 1, 1'b0, 1, 1'b1);    // reset asserted mid-drain
    run_frame(2, -1, -1, 1'b0, -1, 1'b0);  // clean frame after reset

    // Result arriving while idle is a protocol error.
    @(negedge clk);
    conv_valid = 1'b1;
    @(negedge clk);
    conv_valid = 1'b0;
    #1;
    chk("idle_cv_err", error, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
